// File: rtl/spi_sensor_pkg.sv
// Shared types and helpers for the SPI motion-sensor poller.
package spi_sensor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   localparam int READ_BIT = 7;
   localparam int INC_BIT  = 6;

   // Command byte sent ahead of the burst: read flag, auto-increment for
   // multi-byte bursts, then the 6-bit starting register address.
   function automatic logic [7:0] addr_byte(input int num_bytes, input logic [5:0] reg_addr);
      logic [7:0] b;
      b           = {2'b00, reg_addr};
      b[READ_BIT] = 1'b1;
      b[INC_BIT]  = (num_bytes > 1);
      return b;
   endfunction

endpackage

// File: rtl/spi_mode3_shifter.sv
// SPI mode-3 bit engine: SCLK divider plus 8-bit shift register.
// A load starts a byte (SCLK low phase first); MOSI changes on the falling
// SCLK edge, MISO is captured on the rising edge. Loading again on byte_end
// keeps SCLK running back-to-back with no idle-high gap between bytes.
module spi_mode3_shifter #(
   parameter int CLK_DIV = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       load,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       byte_done,
   output logic       byte_end,
   output logic [7:0] rx_byte
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   logic          active;
   logic          phase_hi;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [6:0]    tx_sr;
   logic [6:0]    rx_sr;
   logic          tick;

   assign tick      = active && (div_cnt == '0);
   // byte_done marks the edge that samples the 8th bit; byte_end the edge
   // that closes its high phase.
   assign byte_done = tick && !phase_hi && (bit_cnt == 3'd0);
   assign byte_end  = tick &&  phase_hi && (bit_cnt == 3'd0);
   assign rx_byte   = {rx_sr, miso};

   // Half-period timing, bit sequencing and data shifting.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         active   <= 1'b0;
         phase_hi <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= 3'd0;
         tx_sr    <= 7'd0;
         rx_sr    <= 7'd0;
         sclk     <= 1'b1;
         mosi     <= 1'b0;
      end else if (load && (!active || byte_end)) begin
         active   <= 1'b1;
         phase_hi <= 1'b0;
         div_cnt  <= DIV_LAST;
         bit_cnt  <= 3'd7;
         sclk     <= 1'b0;
         mosi     <= tx_byte[7];
         tx_sr    <= tx_byte[6:0];
      end else if (tick) begin
         div_cnt <= DIV_LAST;
         if (!phase_hi) begin
            sclk     <= 1'b1;
            phase_hi <= 1'b1;
            rx_sr    <= rx_byte[6:0];
         end else if (bit_cnt == 3'd0) begin
            active <= 1'b0;
            mosi   <= 1'b0;
         end else begin
            sclk     <= 1'b0;
            phase_hi <= 1'b0;
            mosi     <= tx_sr[6];
            tx_sr    <= {tx_sr[5:0], 1'b0};
            bit_cnt  <= bit_cnt - 3'd1;
         end
      end else if (active) begin
         div_cnt <= div_cnt - DW'(1);
      end
   end

endmodule

// File: rtl/spi_sensor_poller.sv
// Autonomous SPI burst reader for the observer-board motion sensor.
//
//   state | meaning
//   IDLE  | waiting for start pulse or poll-timer expiry
//   SETUP | CS low, SCLK high, CLK_DIV cycles before first bit
//   SHIFT | address byte then NUM_BYTES data bytes on the bus
//   HOLD  | CS low, SCLK high, CLK_DIV cycles after last bit
//   GAP   | CS high, 2*CLK_DIV cycles before a new trigger is accepted
module spi_sensor_poller
   import spi_sensor_pkg::*;
#(
   parameter int         CLK_DIV     = 4,
   parameter int         NUM_BYTES   = 6,
   parameter logic [5:0] REG_ADDR    = 6'h28,
   parameter int         POLL_PERIOD = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic       i_start,
   output logic       o_sclk,
   output logic       o_cs_n,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_last,
   output logic       o_busy,
   output logic       o_overrun
);

   localparam int            CW         = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(2 * CLK_DIV - 1);
   localparam int            BW         = $clog2(NUM_BYTES + 1);
   localparam logic [BW-1:0] BYTE_LAST  = BW'(NUM_BYTES);
   localparam int            PW         = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
   localparam logic [7:0]    ADDR_BYTE  = addr_byte(NUM_BYTES, REG_ADDR);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [BW-1:0] byte_cnt, byte_cnt_nxt;
   logic [PW-1:0] poll_cnt;
   logic          poll_tick;
   logic          trigger;
   logic          sh_load;
   logic [7:0]    sh_tx;
   logic          sh_byte_done;
   logic          sh_byte_end;
   logic [7:0]    sh_rx_byte;
   logic          data_strobe;

   assign poll_tick   = i_en && (poll_cnt == POLL_LAST);
   assign trigger     = i_start || poll_tick;
   assign o_busy      = (state != IDLE);
   assign o_cs_n      = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
   // Byte 0 is the address echo; only the data bytes go downstream.
   assign data_strobe = sh_byte_done && (state == SHIFT) && (byte_cnt != '0);

   // Free-running poll timer, held at zero while disabled.
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en || poll_tick) begin
         poll_cnt <= '0;
      end else begin
         poll_cnt <= poll_cnt + PW'(1);
      end
   end

   // FSM state and phase counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
      end
   end

   // Next-state logic and shifter control.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      byte_cnt_nxt = byte_cnt;
      sh_load      = 1'b0;
      sh_tx        = 8'h00;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt    = SETUP;
               cnt_nxt      = SETUP_LAST;
               byte_cnt_nxt = '0;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nxt = SHIFT;
               sh_load   = 1'b1;
               sh_tx     = ADDR_BYTE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         SHIFT: begin
            if (sh_byte_end) begin
               if (byte_cnt == BYTE_LAST) begin
                  state_nxt = HOLD;
                  cnt_nxt   = SETUP_LAST;
               end else begin
                  sh_load      = 1'b1;
                  byte_cnt_nxt = byte_cnt + BW'(1);
               end
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LAST;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered byte stream and dropped-trigger flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_data    <= 8'h00;
         o_valid   <= 1'b0;
         o_last    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_valid   <= data_strobe;
         o_last    <= data_strobe && (byte_cnt == BYTE_LAST);
         o_overrun <= trigger && (state != IDLE);
         if (data_strobe) begin
            o_data <= sh_rx_byte;
         end
      end
   end

   spi_mode3_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .load      (sh_load),
      .tx_byte   (sh_tx),
      .miso      (i_miso),
      .sclk      (o_sclk),
      .mosi      (o_mosi),
      .byte_done (sh_byte_done),
      .byte_end  (sh_byte_end),
      .rx_byte   (sh_rx_byte)
   );

endmodule
